// File: rtl/cpu_sram_bridge_pkg.sv
// bridge_pkg: shared definitions for the CPU sram-like to split-channel bus bridge.
//   - bridge_state_e : FSM state encoding (also exported on the debug port)
//   - SIZE_*         : CPU access-size codes (log2 of byte count)
//   - SRC_*          : request source identifiers used by the arbiter and RESP
//   - norm_size()    : folds the reserved size code 3 onto word
//   - gen_strb()     : byte-enable generation from size and low address bits
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // Size code 3 has no meaning on the CPU side; treat it as a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    norm_size = (size == 2'd3) ? SIZE_WORD : size;
  endfunction

  // Byte enables for a store. Halfword accesses are assumed aligned, so only
  // addr[1] selects the upper or lower half.
  function automatic logic [3:0] gen_strb(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: gen_strb = 4'b0001 << addr_lo;
      SIZE_HALF: gen_strb = 4'b0011 << {addr_lo[1], 1'b0};
      default:   gen_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sram_bridge_if.sv
// cpu_sram_bridge_if: system-bus side of the bridge.
//   AR channel : ar_valid/ar_ready, ar_addr, ar_size (log2 bytes)
//   R channel  : r_valid, r_data (the bridge is always ready)
//   AW+W       : aw_valid/aw_ready, aw_addr, aw_size, w_data, w_strb
//   B channel  : b_valid (the bridge is always ready)
// Handshake rule: a transfer happens on a clock edge where valid and ready
// are both 1. Once valid is raised, the source keeps valid and all payload
// fields stable until that edge; ready may toggle freely. r_valid and b_valid
// carry no ready and are consumed only while a response is awaited.
// Modports: master = bridge, slave = memory/bus fabric.
interface cpu_sram_bridge_if #(
  parameter int ADDR_W = 32
) ();

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_size;

  logic              r_valid;
  logic [31:0]       r_data;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_size;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;

  logic              b_valid;

  modport master (
    output ar_valid, ar_addr, ar_size,
    output aw_valid, aw_addr, aw_size, w_data, w_strb,
    input  ar_ready, r_valid, r_data, aw_ready, b_valid
  );

  modport slave (
    input  ar_valid, ar_addr, ar_size,
    input  aw_valid, aw_addr, aw_size, w_data, w_strb,
    output ar_ready, r_valid, r_data, aw_ready, b_valid
  );

endinterface

// File: rtl/cpu_sram_bridge_arb.sv
// bridge_arb: chooses between instruction and data requests.
//   clk, reset : clock and synchronous active-high reset
//   inst_req   : instruction request pending
//   data_req   : data request pending
//   accept     : a request was accepted this cycle (updates round-robin state)
//   grant      : SRC_INST or SRC_DATA; meaningful only when a request is pending
// Configuration macro BRIDGE_RR_ARB_EN: when defined, priority alternates
// after every grant (last grant resets to inst, so data wins first). When
// undefined, data always beats inst.
module bridge_arb
  import bridge_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  input  logic accept,
  output logic grant
);

`ifdef BRIDGE_RR_ARB_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SRC_INST;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  // On contention the source that did not win last time is preferred.
  always_comb begin
    if (inst_req && data_req) begin
      grant = (last_grant == SRC_INST) ? SRC_DATA : SRC_INST;
    end else if (data_req) begin
      grant = SRC_DATA;
    end else begin
      grant = SRC_INST;
    end
  end
`else
  // Fixed priority needs no state; the sequencing inputs are intentionally idle.
  logic unused_arb_inputs;
  assign unused_arb_inputs = ^{clk, reset, accept, inst_req};

  always_comb begin
    grant = data_req ? SRC_DATA : SRC_INST;
  end
`endif

endmodule

// File: rtl/cpu_sram_bridge.sv
// cpu_sram_bridge: converts the CPU's instruction and data sram-like ports
// into one split-channel bus master with a single outstanding transaction.
//   clk, reset       : clock, synchronous active-high reset
//   inst_*           : instruction fetch request/response (read only)
//   data_*           : data load/store request/response
//   rdata            : read data shared by both sources, valid with data_ok
//   bus              : cpu_sram_bridge_if.master (AR/R, AW+W/B)
//   dbg_state        : current FSM state for observation
// Configuration macro BRIDGE_RR_ARB_EN selects round-robin arbitration in
// bridge_arb; the default build uses fixed data-over-inst priority.
// addr_ok is combinational and only ever asserted in IDLE, so accepting a
// request and reporting a completion never happen in the same cycle.
module cpu_sram_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [31:0]         data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,

  output logic [31:0]         rdata,

  cpu_sram_bridge_if.master   bus,

  output bridge_state_e       dbg_state
);

  bridge_state_e     state_q;
  bridge_state_e     state_d;

  logic              grant;
  logic              accept;
  logic              idle_open;
  logic              acc_wr;

  // Transaction latched at acceptance, held until the response arrives.
  logic              src_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       rdata_q;

  logic [1:0]        data_size_n;

  bridge_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .inst_req (inst_req),
    .data_req (data_req),
    .accept   (accept),
    .grant    (grant)
  );

  // Acceptance window: IDLE only, and never while reset is asserted.
  assign idle_open    = (state_q == ST_IDLE) && !reset;
  assign inst_addr_ok = idle_open && inst_req && (grant == SRC_INST);
  assign data_addr_ok = idle_open && data_req && (grant == SRC_DATA);
  assign accept       = inst_addr_ok || data_addr_ok;
  assign acc_wr       = (grant == SRC_DATA) && data_wr;
  assign data_size_n  = norm_size(data_size);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  // r_valid/b_valid are looked at only in the WAIT states, so responses that
  // arrive at any other time (including left-overs from before a reset) are
  // dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept)       state_d = acc_wr ? ST_WR_REQ : ST_RD_REQ;
      ST_RD_REQ:  if (bus.ar_ready) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (bus.r_valid)  state_d = ST_RESP;
      ST_WR_REQ:  if (bus.aw_ready) state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (bus.b_valid)  state_d = ST_RESP;
      ST_RESP:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state_q)
      ST_RD_REQ: bus.ar_valid = 1'b1;
      ST_WR_REQ: bus.aw_valid = 1'b1;
      ST_RESP: begin
        if (src_q == SRC_DATA) begin
          data_data_ok = 1'b1;
        end else begin
          inst_data_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- request latch ----------------
  // Cleared on reset so every bus payload output reads 0 afterwards. Byte
  // enables are computed once here rather than from live inputs so they stay
  // stable for the whole write handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= SRC_INST;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      if (grant == SRC_DATA) begin
        src_q   <= SRC_DATA;
        wr_q    <= data_wr;
        addr_q  <= data_addr;
        size_q  <= data_size_n;
        wdata_q <= data_wdata;
        strb_q  <= gen_strb(data_size_n, data_addr[1:0]);
      end else begin
        src_q   <= SRC_INST;
        wr_q    <= 1'b0;
        addr_q  <= inst_addr;
        size_q  <= SIZE_WORD;
        wdata_q <= '0;
        strb_q  <= 4'b1111;
      end
    end
  end

  // ---------------- read data ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if ((state_q == ST_RD_WAIT) && bus.r_valid) begin
      rdata_q <= bus.r_data;
    end
  end

  // wr_q steers the FSM only at acceptance time via acc_wr; it is kept in the
  // latch so the transaction record is complete for debug.
  logic unused_wr_q;
  assign unused_wr_q = wr_q;

  assign rdata       = rdata_q;
  assign bus.ar_addr = addr_q;
  assign bus.ar_size = {1'b0, size_q};
  assign bus.aw_addr = addr_q;
  assign bus.aw_size = {1'b0, size_q};
  assign bus.w_data  = wdata_q;
  assign bus.w_strb  = strb_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Bench for cpu_sram_bridge: directed scenarios with literal expectations,
// then randomized CPU and bus traffic. A transaction-level model of the bridge
// checks every DUT output on every cycle.
module tb_cpu_sram_bridge;
  import bridge_pkg::*;

  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       rdata;
  bridge_state_e     dbg_state;

  cpu_sram_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_sram_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .rdata        (rdata),
    .bus          (bus),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One transaction at a time: accepted -> request issued on the bus ->
  // response seen -> one completion cycle -> free again.
  bit          m_init = 0;
  bit          m_busy = 0;
  bit          m_sent = 0;
  bit          m_done = 0;
  bit          m_last_data = 0;
  bit          m_src_data = 0;
  bit          m_wr = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_lg = '0;
  logic [31:0] m_strb = '0;
  bit          acc_inst = 0;
  bit          acc_data = 0;

  always @(negedge clk) begin
    bit   gd, e_iok, e_dok, e_val;
    int   sz, lo;
`ifdef BRIDGE_RR_ARB_EN
    gd = (inst_req && data_req) ? !m_last_data : data_req;
`else
    gd = data_req;
`endif
    e_iok = !reset && m_init && !m_busy && inst_req && !gd;
    e_dok = !reset && m_init && !m_busy && data_req && gd;
    e_val = m_busy && !m_sent && !m_done;

    if (m_init) begin
      chk1("inst_addr_ok", inst_addr_ok, e_iok);
      chk1("data_addr_ok", data_addr_ok, e_dok);
      chk1("inst_data_ok", inst_data_ok, m_done && !m_src_data);
      chk1("data_data_ok", data_data_ok, m_done && m_src_data);
      chk("rdata", rdata, m_rdata);
      chk1("ar_valid", bus.ar_valid, e_val && !m_wr);
      chk1("aw_valid", bus.aw_valid, e_val && m_wr);
      if (e_val && !m_wr) begin
        chk("ar_addr", bus.ar_addr, m_addr);
        chk("ar_size", 32'(bus.ar_size), m_lg);
      end
      if (e_val && m_wr) begin
        chk("aw_addr", bus.aw_addr, m_addr);
        chk("aw_size", 32'(bus.aw_size), m_lg);
        chk("w_data", bus.w_data, m_wdata);
        chk("w_strb", 32'(bus.w_strb), m_strb);
      end
    end
    acc_inst = e_iok;
    acc_data = e_dok;

    // Effect of the coming rising edge.
    if (reset) begin
      m_init = 1; m_busy = 0; m_sent = 0; m_done = 0;
      m_rdata = '0; m_last_data = 0;
    end else if (m_init) begin
      if (m_done) begin
        m_busy = 0; m_done = 0;
      end else if (!m_busy) begin
        if (e_iok || e_dok) begin
          m_busy = 1; m_sent = 0;
          m_src_data  = e_dok;
          m_last_data = e_dok;
          m_wr        = e_dok && data_wr;
          m_addr      = e_dok ? data_addr : inst_addr;
          m_wdata     = data_wdata;
          sz          = e_dok ? int'(data_size) : 2;
          if (sz == 3) sz = 2;
          m_lg = 32'(sz);
          lo   = int'(m_addr % 4);
          if (sz == 0)      m_strb = 32'(1 << lo);
          else if (sz == 1) m_strb = 32'(3 << (lo / 2 * 2));
          else              m_strb = 32'd15;
        end
      end else if (!m_sent) begin
        if (m_wr ? bus.aw_ready : bus.ar_ready) m_sent = 1;
      end else if (!m_wr && bus.r_valid) begin
        m_rdata = bus.r_data;
        m_done  = 1;
      end else if (m_wr && bus.b_valid) begin
        m_done = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.ar_ready = 1'b0;
    bus.aw_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.r_data   = '0;
  endtask

  task automatic cpu_idle();
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      nxt();
      if (acc_inst || (inst_req && $urandom_range(0, 15) == 0)) inst_req = 1'b0;
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req  = 1'b1;
        inst_addr = $urandom;
      end
      if (acc_data || (data_req && $urandom_range(0, 15) == 0)) data_req = 1'b0;
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req   = 1'b1;
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 3));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      bus.ar_ready = 1'($urandom_range(0, 1));
      bus.aw_ready = 1'($urandom_range(0, 1));
      bus.r_valid  = ($urandom_range(0, 2) == 0);
      bus.b_valid  = ($urandom_range(0, 2) == 0);
      bus.r_data   = $urandom;
      reset        = ($urandom_range(0, 199) == 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int got;
    reset = 1'b1;
    cpu_idle();
    inst_addr = '0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_idle();
    repeat (3) nxt();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk1("rst_ar_valid", bus.ar_valid, 1'b0);
    chk1("rst_aw_valid", bus.aw_valid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_w_strb", 32'(bus.w_strb), 32'h0);

    // Instruction read, minimum latency.
    nxt(); inst_req = 1'b1; inst_addr = 32'hbfc00000;
    @(negedge clk); chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    nxt(); inst_req = 1'b0; bus.ar_ready = 1'b1;
    @(negedge clk);
    chk1("t1_ar_valid", bus.ar_valid, 1'b1);
    chk("t1_ar_addr", bus.ar_addr, 32'hbfc00000);
    chk("t1_ar_size", 32'(bus.ar_size), 32'd2);
    nxt(); bus.ar_ready = 1'b0; bus.r_valid = 1'b1; bus.r_data = 32'h3c1d0001;
    @(negedge clk); chk1("t1_early_data_ok", inst_data_ok, 1'b0);
    nxt(); bus.r_valid = 1'b0;
    @(negedge clk);
    chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk("t1_rdata", rdata, 32'h3c1d0001);
    chk1("t1_data_data_ok", data_data_ok, 1'b0);

    // Simultaneous inst and data load: data first, inst only after completion.
    nxt();
    inst_req = 1'b1; inst_addr = 32'h00400000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h10000000;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b1; bus.r_data = 32'h11112222;
    @(negedge clk);
    chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
    chk1("t2_inst_held", inst_addr_ok, 1'b0);
    nxt(); data_req = 1'b0;
    @(negedge clk); chk1("t2_inst_wait1", inst_addr_ok, 1'b0);
    nxt(); @(negedge clk); chk1("t2_inst_wait2", inst_addr_ok, 1'b0);
    nxt(); @(negedge clk);
    chk1("t2_data_data_ok", data_data_ok, 1'b1);
    chk1("t2_inst_in_resp", inst_addr_ok, 1'b0);
    chk("t2_rdata", rdata, 32'h11112222);
    nxt(); @(negedge clk); chk1("t2_inst_after", inst_addr_ok, 1'b1);
    nxt(); inst_req = 1'b0;
    repeat (3) nxt();
    bus_idle();

    // Grant order with both sources continuously pending.
    reset = 1'b1; nxt(); reset = 1'b0;
`ifdef BRIDGE_RR_ARB_EN
    exp_q = '{32'd1, 32'd0, 32'd1, 32'd0};
`else
    exp_q = '{32'd1, 32'd1, 32'd1, 32'd1};
`endif
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b1; bus.r_data = 32'h0000cafe;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        chk("grant_order", 32'(data_addr_ok), exp_q.pop_front());
        got++;
      end
      nxt();
    end
    chk("grant_count", 32'(got), 32'd4);
    cpu_idle();
    repeat (4) nxt();
    bus_idle();

    // Byte store with a stalled write channel.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h80000003; data_wdata = 32'hABABABAB;
    @(negedge clk); chk1("t3_data_addr_ok", data_addr_ok, 1'b1);
    nxt(); data_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.aw_ready = (k == 4);
      @(negedge clk);
      chk1("t3_aw_valid", bus.aw_valid, 1'b1);
      chk("t3_aw_addr", bus.aw_addr, 32'h80000003);
      chk("t3_w_strb", 32'(bus.w_strb), 32'h8);
      chk("t3_w_data", bus.w_data, 32'hABABABAB);
      nxt();
    end
    bus.aw_ready = 1'b0; bus.b_valid = 1'b1;
    @(negedge clk);
    chk1("t3_aw_dropped", bus.aw_valid, 1'b0);
    chk1("t3_early_data_ok", data_data_ok, 1'b0);
    nxt(); bus.b_valid = 1'b0;
    @(negedge clk); chk1("t3_data_data_ok", data_data_ok, 1'b1);
    nxt();

    // Half store, upper half.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
    data_addr = 32'h80000002; data_wdata = 32'h5a5a5a5a;
    bus.aw_ready = 1'b1; bus.b_valid = 1'b1;
    @(negedge clk); chk1("t4_data_addr_ok", data_addr_ok, 1'b1);
    nxt(); data_req = 1'b0;
    @(negedge clk);
    chk("t4_w_strb", 32'(bus.w_strb), 32'hC);
    chk("t4_aw_size", 32'(bus.aw_size), 32'd1);
    nxt(); nxt();
    @(negedge clk); chk1("t4_data_data_ok", data_data_ok, 1'b1);
    nxt(); bus_idle();

    // Reset while waiting for read data; the late response must be ignored.
    inst_req = 1'b1; inst_addr = 32'h1fc00010; bus.ar_ready = 1'b1;
    nxt(); inst_req = 1'b0;
    nxt(); bus.ar_ready = 1'b0; reset = 1'b1;
    nxt(); reset = 1'b0; bus.r_valid = 1'b1; bus.r_data = 32'hdeadbeef;
    @(negedge clk);
    chk1("t5_ar_valid", bus.ar_valid, 1'b0);
    chk1("t5_aw_valid", bus.aw_valid, 1'b0);
    chk1("t5_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("t5_data_addr_ok", data_addr_ok, 1'b0);
    chk1("t5_inst_data_ok", inst_data_ok, 1'b0);
    chk("t5_rdata", rdata, 32'h0);
    chk("t5_ar_addr", bus.ar_addr, 32'h0);
    nxt(); @(negedge clk); chk1("t5_no_stale_ok", inst_data_ok, 1'b0);
    nxt(); bus.r_valid = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h00001000;
    bus.ar_ready = 1'b1; bus.r_valid = 1'b1; bus.r_data = 32'h0badf00d;
    @(negedge clk); chk1("t5_next_addr_ok", data_addr_ok, 1'b1);
    nxt(); data_req = 1'b0;
    nxt(); nxt();
    @(negedge clk);
    chk1("t5_next_data_ok", data_data_ok, 1'b1);
    chk("t5_next_rdata", rdata, 32'h0badf00d);
    nxt(); bus_idle();

    // Spurious responses while idle.
    bus.r_valid = 1'b1; bus.b_valid = 1'b1; bus.r_data = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("t6_inst_data_ok", inst_data_ok, 1'b0);
      chk1("t6_data_data_ok", data_data_ok, 1'b0);
      chk("t6_rdata", rdata, 32'h0badf00d);
      nxt();
    end
    bus_idle();

    // Randomized traffic, model-checked every cycle.
    run_random(3000);
    reset = 1'b0;
    cpu_idle();
    bus_idle();
    repeat (5) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sram_bridge.md
Name:
cpu_sram_bridge

Overview:
- Sits directly downstream of the CPU top, between its inst/data memory-request ports and the system bus.
- Converts two sram-like request/response interfaces into the team's simple split-channel bus: AR/R for reads, a combined AW+W request with a B response for writes.
- Keeps exactly one transaction outstanding. Data requests are arbitrated against instruction requests.
- A multi-cycle memory can then stall the pipeline through addr_ok/data_ok.

Parameters:
- ADDR_W, 32, width of all address ports.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction read request.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  one-cycle pulse: rdata valid for inst.
- data_req  in  1  data request.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  32  store data, already lane-replicated by the CPU.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  one-cycle pulse: load data valid or store complete.
- rdata  out  32  shared read data, valid with either data_ok.
- ar_valid  out  1  read address valid.
- ar_ready  in  1  slave accepts read address.
- ar_addr  out  ADDR_W  read address.
- ar_size  out  3  log2 bytes.
- r_valid  in  1  read data return; bridge is always ready.
- r_data  in  32  read data.
- aw_valid  out  1  write request valid (address and data together).
- aw_ready  in  1  slave accepts write request.
- aw_addr  out  ADDR_W  write address.
- aw_size  out  3  log2 bytes.
- w_data  out  32  write data, equal to latched data_wdata, unshifted.
- w_strb  out  4  byte enables.
- b_valid  in  1  write response; bridge is always ready.

Behaviour:
- Reset: the clk edge with reset=1 puts the FSM in IDLE. Next cycle, every output is 0, including rdata and both addr_ok.
- States and transitions:
  - IDLE: picks a source and moves to RD_REQ or WR_REQ.
  - RD_REQ: waits for ar_ready, then RD_WAIT.
  - RD_WAIT: waits for r_valid, then RESP.
  - WR_REQ: waits for aw_ready, then WR_WAIT.
  - WR_WAIT: waits for b_valid, then RESP.
  - RESP: one cycle, then IDLE.
- addr_ok:
  - Combinational; only in IDLE, only for the granted source, and forced to 0 while reset=1.
  - Grant: data_req beats inst_req (fixed priority).
  - On acceptance, latch source, wr, addr, size, wdata. Inst requests use size=2, wr=0.
- Valids: ar_valid=1 only in RD_REQ; aw_valid=1 only in WR_REQ. addr, size, data and strb are held stable until the handshake completes.
- Read data: r_data is registered into rdata on r_valid in RD_WAIT.
- RESP: pulses inst_data_ok or data_data_ok, per the latched source. addr_ok=0 in RESP, so there is no overlap with a new accept.
- Minimum latency: addr_ok at T, valid at T+1, data_ok at T+3 (ready and response each arrive immediately).
- ar_size/aw_size = {1'b0, size}; size 3 is treated as word.
- w_strb by size and address:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << {addr[1], 1'b0}.
  - word: 4'b1111.
- Ignored inputs:
  - r_valid and b_valid outside RD_WAIT/WR_WAIT, including stale responses after reset.
  - Requests that are deasserted before addr_ok are dropped.

Optional Feature:
- BRIDGE_RR_ARB_EN defined: round-robin arbitration. A last-grant flip-flop (reset = inst) flips priority after each grant, so with both requests pending, grants alternate data, inst, data, and so on.
- BRIDGE_RR_ARB_EN undefined: fixed data-over-inst priority.

Decomposition:
- Package bridge_pkg holds:
  - FSM state encoding.
  - SIZE_BYTE/HALF/WORD constants.
  - SRC_INST/SRC_DATA constants.
  - The strb-generation function.
- One sub-module, bridge_arb: inputs inst_req, data_req, an accept strobe, clk and reset; output is the grant. It holds the round-robin state when BRIDGE_RR_ARB_EN is defined.

Test Plan:
- Inst read: inst_req, addr 0xbfc00000, ar_ready=1, r_valid next cycle with 0x3c1d0001.
  -> inst_addr_ok at T; ar_addr=0xbfc00000 and ar_size=2 at T+1; inst_data_ok at T+3 with rdata=0x3c1d0001; data_data_ok stays 0.
- inst_req and data_req (load) together.
  -> data_addr_ok first; inst_addr_ok only in the IDLE cycle after data_data_ok.
  -> With BRIDGE_RR_ARB_EN, over 4 grants the order is data, inst, data, inst.
- Byte store, addr 0x80000003, wdata 0xABABABAB, aw_ready held 0 for 4 cycles.
  -> aw_valid=1 and aw_addr/w_strb=4'b1000 stable for 5 cycles; data_data_ok one cycle after b_valid.
- Half store, addr 0x80000002.
  -> w_strb=4'b1100, aw_size=1.
- reset pulsed in RD_WAIT, then r_valid arrives.
  -> No data_ok. All valids and addr_ok are 0 the cycle after reset; the next request proceeds normally.
- r_valid/b_valid asserted spuriously in IDLE.
  -> No data_ok, and rdata is unchanged.
